i2c_target_regfile: RTL
=======================

I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit I2C device address this target answers to.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port scl_in  input  1  raw SCL line level, asynchronous to clk.
REQ-005 SHALL have port sda_in  input  1  raw SDA line level, asynchronous to clk.
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain, external pull-up).
REQ-007 SHALL have port busy  output  1  high from the matched-address ACK until STOP or a return to IDLE.
REQ-008 SHALL have port wr_strobe  output  1  one-clk pulse per accepted write data byte.
REQ-009 SHALL have port wr_addr  output  4  register index of the current wr_strobe.
REQ-010 SHALL have port wr_data  output  8  data byte of the current wr_strobe.
REQ-011 SHALL have port host_addr  input  4  local read index into the register file.
REQ-012 SHALL have port host_data  output  8  regfile[host_addr], registered with 1-clk latency.

Function
REQ-013 SHALL pass scl_in and sda_in each through a 2-flop synchronizer plus 1 history flop; all edges and levels below refer to the synchronized signals.
REQ-014 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-015 SHALL sample SDA on the clk after an SCL rising edge is detected, and change sda_oe only on the clk after an SCL falling edge is detected.
REQ-016 SHALL hold a 16x8 register file and a 4-bit pointer ptr.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK.
REQ-018 SHALL enter ADDR on START (including repeated START) from any state, and enter IDLE with sda_oe=0 on STOP from any state.
REQ-019 ADDR SHALL shift in 8 bits MSB first; at the 8th bit, a match of bits[7:1] with DEV_ADDR goes to ADDR_ACK, and a mismatch goes to IDLE with no ACK.
REQ-020 Each *_ACK state SHALL assert sda_oe from the SCL falling edge after the 8th bit until the next SCL falling edge, then release it.
REQ-021 After ADDR_ACK, R/W=0 SHALL go to SUB; R/W=1 SHALL load regfile[ptr] and go to RDATA.
REQ-022 SUB: sub-address < 8'h10 SHALL set ptr=sub[3:0] and ACK (SUB_ACK to WDATA).
REQ-023 SUB: sub-address >= 8'h10 SHALL NACK (sda_oe stays 0) and go to IDLE.
REQ-024 WDATA SHALL, at the 8th bit, write regfile[ptr], pulse wr_strobe with wr_addr=ptr and wr_data=byte, ACK, increment ptr with 15->0 wrap, and return to WDATA.
REQ-025 RDATA SHALL drive sda_oe=~bit, MSB first, at each SCL falling edge; it SHALL release SDA after bit 0 and go to RACK.
REQ-026 RACK SHALL sample the master bit. ACK (0): ptr++ (wrap), load regfile[ptr], go to RDATA. NACK (1): go to IDLE with SDA released.
REQ-027 A repeated START after SUB_ACK SHALL retain ptr, giving a combined write-pointer/read transaction.
REQ-028 A STOP or START arriving mid-byte SHALL discard the partial byte with no wr_strobe.
REQ-029 busy SHALL rise with ADDR_ACK entry and fall on entry to IDLE.

Reset
REQ-030 While reset=0 at a clk edge: sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, host_data=0, ptr=0, all regfile entries 8'h00, state=IDLE, synchronizers=1 (bus idle).
REQ-031 Reset asserted mid-transaction SHALL release SDA on the next clk; the block SHALL ignore the bus until the next START.

Verification
REQ-032 clk 100 ns period, SCL 2 us period. Bytes 0x34, 0x03, 0x5A, then STOP -> ACK on all three bytes; single wr_strobe with wr_addr=3, wr_data=0x5A; host_addr=3 gives host_data=0x5A one clk later; busy=0 after STOP.
REQ-033 Bytes 0x34, 0x0F, 0x11, 0x22, then STOP -> regfile[15]=0x11, regfile[0]=0x22, two wr_strobes (addr 15 then 0).
REQ-034 Byte 0x36 -> sda_oe stays 0 through the 9th clock and the rest of the transfer; no wr_strobe; busy stays 0.
REQ-035 After REQ-032: bytes 0x34, 0x03, repeated START, 0x35; master ACKs byte 1 and NACKs byte 2 -> SDA carries 0x5A then 0x00; SDA released after the NACK; busy=0 after STOP.
REQ-036 Bytes 0x34, 0x1B -> ACK on the address byte, NACK on the sub-address byte, no wr_strobe, sda_oe=0 afterwards.
REQ-037 reset=0 during bit 4 of the data byte in REQ-032 -> sda_oe=0 next clk, regfile[3]=0x00, no wr_strobe; a subsequent full REQ-032 sequence succeeds.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a 16x8 register file: write with a sub-address pointer,
// read back sequentially with auto-increment, plus a local host read port.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [3:0] host_addr,
  output logic [7:0] host_data
);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StAddr     = 4'd1;
  localparam logic [3:0] StAddrAck  = 4'd2;
  localparam logic [3:0] StSub      = 4'd3;
  localparam logic [3:0] StSubAck   = 4'd4;
  localparam logic [3:0] StWdata    = 4'd5;
  localparam logic [3:0] StWdataAck = 4'd6;
  localparam logic [3:0] StRdata    = 4'd7;
  localparam logic [3:0] StRack     = 4'd8;

  logic [2:0] scl_sync_q, sda_sync_q;
  logic       scl, scl_prev, sda, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det;

  logic [3:0] state_q;
  logic [3:0] cnt_q;
  logic [7:0] shift_q;
  logic       rw_q;
  logic       ack_drv_q;
  logic [3:0] ptr_q;
  logic [7:0] regs_q [16];
  logic [7:0] byte_in;
  logic       last_bit;

  // Bits [1:0] synchronize; bit [2] is the history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl_in};
      sda_sync_q <= {sda_sync_q[1:0], sda_in};
    end
  end

  always_comb begin
    scl       = scl_sync_q[1];
    scl_prev  = scl_sync_q[2];
    sda       = sda_sync_q[1];
    sda_prev  = sda_sync_q[2];
    scl_rise  = scl & ~scl_prev;
    scl_fall  = ~scl & scl_prev;
    start_det = scl & scl_prev & sda_prev & ~sda;
    stop_det  = scl & scl_prev & ~sda_prev & sda;
    byte_in   = {shift_q[6:0], sda};
    last_bit  = (cnt_q == 4'd7);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      ack_drv_q <= 1'b0;
      ptr_q     <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      host_data <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      host_data <= regs_q[host_addr];
      if (stop_det) begin
        state_q <= StIdle;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (start_det) begin
        state_q   <= StAddr;
        cnt_q     <= '0;
        ack_drv_q <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        case (state_q)
          StAddr, StSub, StWdata: begin
            if (scl_rise) begin
              shift_q <= byte_in;
              cnt_q   <= cnt_q + 4'd1;
              if (last_bit) begin
                cnt_q     <= '0;
                ack_drv_q <= 1'b0;
                if (state_q == StAddr) begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                    state_q <= StAddrAck;
                    rw_q    <= byte_in[0];
                    busy    <= 1'b1;
                  end else begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                  end
                end else if (state_q == StSub) begin
                  if (byte_in < 8'h10) begin
                    ptr_q   <= byte_in[3:0];
                    state_q <= StSubAck;
                  end else begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                  end
                end else begin
                  regs_q[ptr_q] <= byte_in;
                  wr_strobe     <= 1'b1;
                  wr_addr       <= ptr_q;
                  wr_data       <= byte_in;
                  ptr_q         <= ptr_q + 4'd1;
                  state_q       <= StWdataAck;
                end
              end
            end
          end
          // First falling edge pulls SDA for the ACK slot, the second ends it.
          StAddrAck, StSubAck, StWdataAck: begin
            if (scl_fall) begin
              if (!ack_drv_q) begin
                sda_oe    <= 1'b1;
                ack_drv_q <= 1'b1;
              end else begin
                ack_drv_q <= 1'b0;
                sda_oe    <= 1'b0;
                cnt_q     <= '0;
                if (state_q == StAddrAck && rw_q) begin
                  sda_oe  <= ~regs_q[ptr_q][7];
                  shift_q <= {regs_q[ptr_q][6:0], 1'b0};
                  cnt_q   <= 4'd1;
                  state_q <= StRdata;
                end else if (state_q == StAddrAck) begin
                  state_q <= StSub;
                end else begin
                  state_q <= StWdata;
                end
              end
            end
          end
          StRdata: begin
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe  <= 1'b0;
                state_q <= StRack;
              end else begin
                sda_oe  <= ~shift_q[7];
                shift_q <= {shift_q[6:0], 1'b0};
                cnt_q   <= cnt_q + 4'd1;
              end
            end
          end
          StRack: begin
            if (scl_rise) begin
              if (!sda) begin
                ptr_q   <= ptr_q + 4'd1;
                shift_q <= regs_q[ptr_q + 4'd1];
                cnt_q   <= '0;
                state_q <= StRdata;
              end else begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end
            end
          end
          StIdle: ;
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
            sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
